// File: rtl/mcu_spi_if.sv
// SPI mode-0 target front end: oversamples the MCU's SPI lines in the core clock
// domain, deserialises MOSI into byte strobes and serialises the reply byte on MISO.
`timescale 1ns/1ps
module mcu_spi_if #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_io_ss,
   input  logic       spi_io_clk,
   input  logic       spi_io_din,
   output logic       spi_io_dout,
   output logic       spi_io_dout_oe,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       rx_start,
   input  logic [7:0] tx_data,
   output logic       active,
   output logic       frame_abort
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   logic                   r_sck_p;
   logic                   r_ss_p;

   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic       r_first;
   logic [7:0] r_rx_shift;
   logic [7:0] r_tx_shift;

   logic w_ss_s;
   logic w_sck_s;
   logic w_din_s;
   logic w_rise;
   logic w_fall;
   logic w_ss_fall;

   assign w_ss_s  = r_ss_sync[SYNC_STAGES-1];
   assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
   assign w_din_s = r_din_sync[SYNC_STAGES-1];

   assign w_rise    = w_sck_s & ~r_sck_p;
   assign w_fall    = ~w_sck_s & r_sck_p;
   assign w_ss_fall = ~w_ss_s & r_ss_p;

   // Synchronisers and edge history. r_vld marks when ss_s carries a real sample,
   // so a select already low at reset release is not mistaken for a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ss_sync  <= {SYNC_STAGES{1'b1}};
         r_sck_sync <= {SYNC_STAGES{1'b0}};
         r_din_sync <= {SYNC_STAGES{1'b0}};
         r_vld      <= {SYNC_STAGES{1'b0}};
         r_sck_p    <= 1'b0;
         r_ss_p     <= 1'b0;
      end else begin
         r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], spi_io_ss};
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_io_clk};
         r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi_io_din};
         r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_sck_p    <= w_sck_s;
         r_ss_p     <= r_vld[SYNC_STAGES-1] ? w_ss_s : 1'b0;
      end
   end

   // Frame state machine with shift registers and registered strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_first     <= 1'b0;
         r_rx_shift  <= 8'h00;
         r_tx_shift  <= 8'h00;
         rx_data     <= 8'h00;
         rx_strobe   <= 1'b0;
         rx_start    <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         rx_strobe   <= 1'b0;
         rx_start    <= 1'b0;
         frame_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ss_fall) begin
                  r_state    <= ST_SHIFT;
                  r_bit_cnt  <= 3'd0;
                  r_first    <= 1'b1;
                  r_tx_shift <= 8'h00;
               end
            end
            ST_SHIFT: begin
               // A deasserted select overrides any SPI clock edge in the same cycle.
               if (w_ss_s) begin
                  r_state     <= ST_IDLE;
                  frame_abort <= (r_bit_cnt != 3'd0);
                  r_bit_cnt   <= 3'd0;
                  r_first     <= 1'b0;
                  r_tx_shift  <= 8'h00;
               end else if (w_rise) begin
                  r_rx_shift <= {r_rx_shift[6:0], w_din_s};
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     rx_data   <= {r_rx_shift[6:0], w_din_s};
                     rx_strobe <= 1'b1;
                     rx_start  <= r_first;
                     r_first   <= 1'b0;
                  end
               end else if (w_fall) begin
                  if (r_bit_cnt != 3'd0) begin
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end else if (!r_first) begin
                     r_tx_shift <= tx_data;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // tx_shift is cleared whenever the frame is idle, so its MSB is the MISO line.
   assign spi_io_dout    = r_tx_shift[7];
   assign active         = (r_state == ST_SHIFT);
   assign spi_io_dout_oe = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_mcu_spi_if.sv
// Directed bench for mcu_spi_if: drives SPI frames as the MCU and checks the
// received bytes, strobe qualifiers, MISO bytes and frame_abort behaviour.
`timescale 1ns/1ps
module tb_mcu_spi_if;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       spi_io_ss = 1'b1;
   logic       spi_io_clk = 1'b0;
   logic       spi_io_din = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       spi_io_dout, spi_io_dout_oe, rx_strobe, rx_start, active, frame_abort;
   logic [7:0] rx_data;

   int n_pass = 0;
   int n_total = 0;
   int half = 8;
   int n_abort = 0;
   int n_bad_start = 0;
   logic [7:0] rxq[$];
   logic       stq[$];

   mcu_spi_if #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .reset_n(reset_n), .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk),
      .spi_io_din(spi_io_din), .spi_io_dout(spi_io_dout), .spi_io_dout_oe(spi_io_dout_oe),
      .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_start(rx_start), .tx_data(tx_data),
      .active(active), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   // Record every strobe and abort pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_strobe) begin
         rxq.push_back(rx_data);
         stq.push_back(rx_start);
      end
      if (frame_abort) n_abort++;
      if (rx_start && !rx_strobe) n_bad_start++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [7:0] mosi, input int nbits, input logic [7:0] tx_next,
                           output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_io_din = mosi[i];
         clks(half);
         miso[i] = spi_io_dout;
         spi_io_clk = 1'b1;
         clks(half);
         if (i == 0) tx_data = tx_next;
         spi_io_clk = 1'b0;
      end
   endtask

   task automatic frame_start();
      spi_io_ss = 1'b0;
      clks(half);
   endtask

   task automatic frame_end();
      clks(half);
      spi_io_ss = 1'b1;
      clks(SS + 4);
   endtask

   function automatic logic [31:0] outs();
      return {16'h0, rx_data, rx_strobe, rx_start, spi_io_dout, spi_io_dout_oe, active, frame_abort, 2'b00};
   endfunction

   initial begin
      logic [7:0] m0, m1, m2, m3;
      logic [7:0] mo[16];
      logic [7:0] tv[16];
      logic [7:0] mi[16];

      // Reset with SPI idle
      clks(3);
      chk("reset_outs", outs(), 32'h0);
      reset_n = 1'b1;
      clks(10);
      chk("idle_outs", outs(), 32'h0);

      // Status command: four 00 bytes, replies 5c/42/05
      rxq.delete(); stq.delete();
      frame_start();
      spi_bits(8'h00, 8, 8'h5c, m0);
      spi_bits(8'h00, 8, 8'h42, m1);
      chk("active_mid", {30'h0, active, spi_io_dout_oe}, 32'h3);
      spi_bits(8'h00, 8, 8'h05, m2);
      spi_bits(8'h00, 8, 8'h00, m3);
      frame_end();
      chk("st_count", rxq.size(), 32'd4);
      for (int j = 0; j < 4; j++) begin
         chk("st_data", rxq[j], 32'h00);
         chk("st_start", stq[j], (j == 0) ? 32'd1 : 32'd0);
      end
      chk("st_miso0", m0, 32'h00);
      chk("st_miso1", m1, 32'h5c);
      chk("st_miso2", m2, 32'h42);
      chk("st_miso3", m3, 32'h05);

      // Read command 04 'R' 00, clean end
      rxq.delete(); stq.delete(); n_abort = 0;
      frame_start();
      spi_bits(8'h04, 8, 8'h11, m0);
      spi_bits(8'h52, 8, 8'h22, m1);
      spi_bits(8'h00, 8, 8'h33, m2);
      frame_end();
      chk("rd_count", rxq.size(), 32'd3);
      chk("rd_d0", rxq[0], 32'h04);
      chk("rd_d1", rxq[1], 32'h52);
      chk("rd_d2", rxq[2], 32'h00);
      chk("rd_starts", {29'h0, stq[0], stq[1], stq[2]}, 32'h4);
      chk("rd_inactive", {30'h0, active, spi_io_dout_oe}, 32'h0);
      chk("rd_no_abort", n_abort, 32'd0);
      chk("rd_miso2", m2, 32'h22);

      // Abort after 5 bits of byte 1
      rxq.delete(); stq.delete(); n_abort = 0;
      frame_start();
      spi_bits(8'h03, 8, 8'h00, m0);
      spi_bits(8'hff, 5, 8'h00, m1);
      frame_end();
      chk("ab_count", rxq.size(), 32'd1);
      chk("ab_data", rxq[0], 32'h03);
      chk("ab_start", stq[0], 32'd1);
      chk("ab_pulses", n_abort, 32'd1);
      rxq.delete(); stq.delete();
      frame_start();
      spi_bits(8'ha7, 8, 8'h00, m0);
      frame_end();
      chk("ab_next_count", rxq.size(), 32'd1);
      chk("ab_next_data", rxq[0], 32'ha7);
      chk("ab_next_start", stq[0], 32'd1);

      // Back-to-back frames separated by one clk of ss high
      rxq.delete(); stq.delete(); n_abort = 0;
      frame_start();
      spi_bits(8'h11, 8, 8'h77, m0);
      spi_bits(8'h22, 8, 8'h99, m1);
      clks(half);
      spi_io_ss = 1'b1;
      clks(1);
      spi_io_ss = 1'b0;
      clks(half);
      spi_bits(8'h33, 8, 8'h6e, m2);
      spi_bits(8'h44, 8, 8'h00, m3);
      frame_end();
      chk("bb_miso1", m1, 32'h77);
      chk("bb_miso_f2b0", m2, 32'h00);
      chk("bb_miso_f2b1", m3, 32'h6e);
      chk("bb_count", rxq.size(), 32'd4);
      chk("bb_data", {rxq[0], rxq[1], rxq[2], rxq[3]}, 32'h11223344);
      chk("bb_starts", {28'h0, stq[0], stq[1], stq[2], stq[3]}, 32'ha);
      chk("bb_no_abort", n_abort, 32'd0);

      // Reset asserted mid-frame, released with ss still low
      rxq.delete(); stq.delete(); n_abort = 0;
      frame_start();
      spi_bits(8'hf0, 3, 8'h00, m0);
      chk("mr_pre_active", active, 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mr_async_outs", outs(), 32'h0);
      clks(2);
      reset_n = 1'b1;
      spi_bits(8'h5a, 8, 8'h00, m0);
      clks(half);
      chk("mr_no_strobe", rxq.size(), 32'd0);
      chk("mr_idle", active, 32'd0);
      frame_end();
      frame_start();
      spi_bits(8'hc3, 8, 8'h00, m0);
      frame_end();
      chk("mr_fresh_count", rxq.size(), 32'd1);
      chk("mr_fresh_data", rxq[0], 32'hc3);
      chk("mr_fresh_start", stq[0], 32'd1);

      // Minimum clock ratio, 16 random bytes
      rxq.delete(); stq.delete(); n_abort = 0;
      half = SS + 2;
      for (int j = 0; j < 16; j++) begin
         mo[j] = 8'($urandom);
         tv[j] = 8'($urandom);
      end
      frame_start();
      for (int j = 0; j < 16; j++) spi_bits(mo[j], 8, tv[j], mi[j]);
      frame_end();
      chk("mn_count", rxq.size(), 32'd16);
      chk("mn_miso0", mi[0], 32'h00);
      for (int j = 0; j < 16; j++) begin
         chk("mn_rx", rxq[j], mo[j]);
         if (j > 0) chk("mn_miso", mi[j], tv[j-1]);
      end
      chk("mn_no_abort", n_abort, 32'd0);

      chk("start_only_with_strobe", n_bad_start, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
